rx_8b9b_frame_ctrl: RTL and testbench
=====================================

RX_8B9B_FRAME_CTRL -- requirements
Module: rx_8b9b_frame_ctrl

Interface
REQ-001 Parameters SHALL be: WORD_WIDTH, default 8, word width; MAX_WORDS, default 16, frame buffer depth (power of two, 2..256); TIMEOUT_CYCLES, default 64, inter-word timeout limit (>=2).
REQ-002 clk  in  1  single clock for all logic, same domain as the 8b9b receiver word side.
REQ-003 async_reset  in  1  asynchronous, active-high reset.
REQ-004 arm  in  1  one-cycle pulse; requests capture of one frame.
REQ-005 continuous  in  1  level; when high, re-arm automatically after each drained frame.
REQ-006 rx_enable  out  1  enable to the 8b9b receiver.
REQ-007 rx_word  in  WORD_WIDTH  received word.
REQ-008 rx_word_write  in  1  rx_word valid strobe.
REQ-009 rx_frame_complete  in  1  end-of-frame strobe; may coincide with rx_word_write.
REQ-010 frame_word  out  WORD_WIDTH  buffered word being presented.
REQ-011 frame_valid / frame_ready  out / in  1 / 1  output handshake; transfer on both high at a rising clk edge.
REQ-012 frame_last  out  1  high with the final word of a frame.
REQ-013 frame_len  out  clog2(MAX_WORDS+1)  word count of the frame being drained; held during DRAIN.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 overflow_err / timeout_err  out  1 / 1  one-cycle error pulses.

Function
REQ-016 States SHALL be IDLE, ARMED, CAPTURE, DISCARD, DRAIN.
REQ-017 IDLE: arm=1 -> ARMED; write pointer cleared.
REQ-018 rx_enable SHALL be 1 in ARMED, CAPTURE and DISCARD, and 0 in IDLE and DRAIN.
REQ-019 ARMED: rx_word_write=1 -> store the word at address 0, count=1, go to CAPTURE; if rx_frame_complete=1 in the same cycle, go directly to DRAIN with frame_len=1.
REQ-020 CAPTURE: each rx_word_write stores rx_word at address count and increments count; when rx_frame_complete=1, go to DRAIN, including the word written in that same cycle.
REQ-021 rx_frame_complete without rx_word_write SHALL end the frame using the current count; in ARMED it SHALL be ignored.
REQ-022 rx_word_write when count==MAX_WORDS: drop the word, pulse overflow_err once, go to DISCARD.
REQ-023 DISCARD: ignore words; on rx_frame_complete return to ARMED with count=0.
REQ-024 DRAIN: frame_valid=1 registered, first asserted the cycle after entry; frame_word=buffer[rd_ptr]; frame_last=(rd_ptr==frame_len-1); rd_ptr advances on each transfer.
REQ-025 frame_word, frame_last and frame_valid SHALL be held stable while frame_valid=1 and frame_ready=0.
REQ-026 The transfer of the last word SHALL go to ARMED if continuous=1, otherwise to IDLE; frame_valid SHALL be 0 the following cycle.
REQ-027 arm SHALL be ignored outside IDLE.
REQ-028 Latency: first frame_word SHALL be valid 2 clk cycles after the cycle in which rx_frame_complete is sampled.
REQ-029 Buffer SHALL be a synchronous-write RAM with registered read; a word is never written and read in the same cycle.

Reset
REQ-030 async_reset=1 SHALL immediately force IDLE, with rx_enable, frame_valid, frame_last, busy, overflow_err, timeout_err=0 and count, rd_ptr, frame_len=0; buffer contents are undefined.
REQ-031 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abandon the frame; no output transfers SHALL occur until a new arm is received.
REQ-032 Deassertion SHALL take effect at the next clk edge; there is no synchroniser inside the block.

Configuration
REQ-033 Macro RX_FRAME_TIMEOUT_EN: when defined, a counter SHALL clear on entry to CAPTURE and on each rx_word_write, and increment otherwise in CAPTURE. Reaching TIMEOUT_CYCLES SHALL pulse timeout_err, drop the frame and return to ARMED with count=0.
REQ-034 When RX_FRAME_TIMEOUT_EN is undefined, there SHALL be no timeout counter logic, timeout_err SHALL be tied to 0, and CAPTURE SHALL wait indefinitely.

Verification
REQ-035 Sequence: arm, 3 words 0x11, 0x22, 0x33 with complete on 0x33, frame_ready=1 -> output 0x11, 0x22, 0x33; frame_len=3; frame_last only on 0x33; ends in IDLE.
REQ-036 Single word 0xA5 with rx_word_write and rx_frame_complete in the same cycle -> frame_len=1, frame_last=1 on 0xA5.
REQ-037 17 words with MAX_WORDS=16 -> overflow_err pulses once on word 17, no output until the next frame, state ARMED.
REQ-038 During DRAIN, toggle frame_ready 1/0 every cycle -> no word is duplicated or skipped, outputs are stable while stalled, and rx_enable=0 throughout.
REQ-039 With RX_FRAME_TIMEOUT_EN defined, 2 words then silence -> timeout_err pulses on cycle 64 after the last word, state ARMED. Without the macro, the state stays CAPTURE.
REQ-040 continuous=1 with two back-to-back frames -> both drained in order, returning to ARMED after each; assert async_reset during the second DRAIN -> frame_valid=0 at once, state IDLE.

Source files
------------

// File: rtl/rx_8b9b_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_8b9b_frame_ctrl_if
// Description : Bundles the control, receiver-side and frame-output signals
//               of rx_8b9b_frame_ctrl.
//               master : the environment (arms capture, feeds received words,
//                        consumes buffered frame words)
//               slave  : the frame controller itself
//               Signals: arm, continuous, rx_enable, rx_word, rx_word_write,
//                        rx_frame_complete, frame_word, frame_valid,
//                        frame_ready, frame_last, frame_len, busy,
//                        overflow_err, timeout_err
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_8b9b_frame_ctrl_if #(
    parameter int WORD_WIDTH = 8,
    parameter int MAX_WORDS  = 16
);
    localparam int c_LEN_W = $clog2(MAX_WORDS + 1);

    logic                  arm;
    logic                  continuous;
    logic                  rx_enable;
    logic [WORD_WIDTH-1:0] rx_word;
    logic                  rx_word_write;
    logic                  rx_frame_complete;
    logic [WORD_WIDTH-1:0] frame_word;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  frame_last;
    logic [c_LEN_W-1:0]    frame_len;
    logic                  busy;
    logic                  overflow_err;
    logic                  timeout_err;

    modport master (
        output arm, continuous, rx_word, rx_word_write, rx_frame_complete,
               frame_ready,
        input  rx_enable, frame_word, frame_valid, frame_last, frame_len,
               busy, overflow_err, timeout_err
    );

    modport slave (
        input  arm, continuous, rx_word, rx_word_write, rx_frame_complete,
               frame_ready,
        output rx_enable, frame_word, frame_valid, frame_last, frame_len,
               busy, overflow_err, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/rx_8b9b_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_8b9b_frame_ctrl
// Description : Captures one frame of words from an 8b9b receiver into a
//               local buffer, then drains it over a valid/ready handshake.
//               Optional inter-word timeout enabled by macro
//               RX_FRAME_TIMEOUT_EN.
// Ports       : clk         - single clock
//               async_reset - asynchronous active-high reset
//               bus         - rx_8b9b_frame_ctrl_if.slave (control, receiver
//                             word side, frame output, status/errors)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_8b9b_frame_ctrl #(
    parameter int WORD_WIDTH     = 8,
    parameter int MAX_WORDS      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire                 clk,
    input  wire                 async_reset,
    rx_8b9b_frame_ctrl_if.slave bus
);
    localparam int c_LEN_W = $clog2(MAX_WORDS + 1);
    localparam int c_AW    = $clog2(MAX_WORDS);

    localparam logic [c_LEN_W-1:0] c_LEN_ONE  = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0] c_MAX_CNT  = c_LEN_W'(MAX_WORDS);
    localparam logic [c_AW-1:0]    c_ADDR_ONE = c_AW'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ARMED   = 3'd1;
    localparam logic [2:0] c_CAPTURE = 3'd2;
    localparam logic [2:0] c_DISCARD = 3'd3;
    localparam logic [2:0] c_DRAIN   = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_LEN_W-1:0]    r_count;
    logic [c_LEN_W-1:0]    r_frame_len;
    logic [c_LEN_W-1:0]    r_rd_ptr;
    logic [WORD_WIDTH-1:0] r_frame_word;
    logic                  r_frame_valid;
    logic                  r_overflow_err;
    logic [WORD_WIDTH-1:0] r_mem [MAX_WORDS];

    logic                  w_wr_en;
    logic [c_AW-1:0]       w_wr_addr;
    logic                  w_overflow;
    logic                  w_timeout;
    logic                  w_timer_hit;
    logic [c_LEN_W-1:0]    w_len_next;
    logic                  w_last;
    logic [c_AW-1:0]       w_rd_next_addr;
    logic                  w_rx_enable;
    logic                  w_busy;
    logic                  w_frame_last;

    // rd_ptr indexes the word currently presented on frame_word.
    assign w_last         = (r_rd_ptr == r_frame_len - c_LEN_ONE);
    assign w_rd_next_addr = r_rd_ptr[c_AW-1:0] + c_ADDR_ONE;

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_TIMER_ONE = c_TW'(1);
    localparam logic [c_TW-1:0] c_TIMER_END = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_timer;
    logic            r_timeout_err;

    // Held at zero outside CAPTURE, so it is already clear on CAPTURE entry.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_timer <= '0;
        end else if (r_state != c_CAPTURE || bus.rx_word_write) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TIMER_ONE;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) r_timeout_err <= 1'b0;
        else             r_timeout_err <= w_timeout;
    end

    assign w_timer_hit     = (r_timer == c_TIMER_END);
    assign bus.timeout_err = r_timeout_err;
`else
    // Keeps the parameter referenced in builds without the timer.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_timer_hit          = 1'b0;
    assign bus.timeout_err      = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) r_state <= c_IDLE;
        else             r_state <= w_next_state;
    end

    // ---------------- next state and capture strobes ----------------
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_overflow   = 1'b0;
        w_timeout    = 1'b0;
        w_len_next   = r_count;
        case (r_state)
            c_IDLE: begin
                if (bus.arm) w_next_state = c_ARMED;
            end
            c_ARMED: begin
                // A bare frame_complete here has no words behind it: ignored.
                if (bus.rx_word_write) begin
                    w_wr_en = 1'b1;
                    if (bus.rx_frame_complete) begin
                        w_next_state = c_DRAIN;
                        w_len_next   = c_LEN_ONE;
                    end else begin
                        w_next_state = c_CAPTURE;
                    end
                end
            end
            c_CAPTURE: begin
                if (bus.rx_word_write) begin
                    if (r_count == c_MAX_CNT) begin
                        w_overflow = 1'b1;
                        // If this word also closes the frame there is nothing
                        // left to discard, so re-arm straight away.
                        w_next_state = bus.rx_frame_complete ? c_ARMED : c_DISCARD;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_count[c_AW-1:0];
                        if (bus.rx_frame_complete) begin
                            w_next_state = c_DRAIN;
                            w_len_next   = r_count + c_LEN_ONE;
                        end
                    end
                end else if (bus.rx_frame_complete) begin
                    w_next_state = c_DRAIN;
                end else if (w_timer_hit) begin
                    w_timeout    = 1'b1;
                    w_next_state = c_ARMED;
                end
            end
            c_DISCARD: begin
                if (bus.rx_frame_complete) w_next_state = c_ARMED;
            end
            c_DRAIN: begin
                if (r_frame_valid && bus.frame_ready && w_last)
                    w_next_state = bus.continuous ? c_ARMED : c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        w_rx_enable  = (r_state == c_ARMED) || (r_state == c_CAPTURE) ||
                       (r_state == c_DISCARD);
        w_busy       = (r_state != c_IDLE);
        w_frame_last = r_frame_valid && w_last;
    end

    assign bus.rx_enable    = w_rx_enable;
    assign bus.busy         = w_busy;
    assign bus.frame_last   = w_frame_last;
    assign bus.frame_valid  = r_frame_valid;
    assign bus.frame_word   = r_frame_word;
    assign bus.frame_len    = r_frame_len;
    assign bus.overflow_err = r_overflow_err;

    // ---------------- frame buffer (write port) ----------------
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= bus.rx_word;
    end

    // ---------------- counters and registered read ----------------
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_count        <= '0;
            r_frame_len    <= '0;
            r_rd_ptr       <= '0;
            r_frame_word   <= '0;
            r_frame_valid  <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_overflow_err <= w_overflow;

            if (r_state == c_IDLE)
                r_count <= '0;
            else if (w_wr_en)
                r_count <= (r_state == c_ARMED) ? c_LEN_ONE : r_count + c_LEN_ONE;
            else if (w_next_state == c_ARMED)
                r_count <= '0;

            if (r_state != c_DRAIN && w_next_state == c_DRAIN) begin
                r_frame_len <= w_len_next;
                r_rd_ptr    <= '0;
            end

            // First DRAIN cycle fetches word 0; afterwards the next word is
            // fetched only on a transfer, so stalls hold the output register.
            if (r_state == c_DRAIN) begin
                if (!r_frame_valid) begin
                    r_frame_word  <= r_mem[r_rd_ptr[c_AW-1:0]];
                    r_frame_valid <= 1'b1;
                end else if (bus.frame_ready) begin
                    if (w_last) begin
                        r_frame_valid <= 1'b0;
                    end else begin
                        r_rd_ptr     <= r_rd_ptr + c_LEN_ONE;
                        r_frame_word <= r_mem[w_rd_next_addr];
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rx_8b9b_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_8b9b_frame_ctrl
// Description : Directed self-checking bench for rx_8b9b_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_8b9b_frame_ctrl;
    logic clk;
    logic async_reset;
    int   n_checks;
    int   n_fail;

    logic [7:0] got_word [32];
    logic       got_last [32];
    int         got_n;
    bit         got_to;

    rx_8b9b_frame_ctrl_if #(.WORD_WIDTH(8), .MAX_WORDS(16)) bus_if ();

    rx_8b9b_frame_ctrl #(
        .WORD_WIDTH    (8),
        .MAX_WORDS     (16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .bus        (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        bus_if.arm = 1'b1;
        tick();
        bus_if.arm = 1'b0;
    endtask

    task automatic send(input logic [7:0] w, input logic c);
        bus_if.rx_word           = w;
        bus_if.rx_word_write     = 1'b1;
        bus_if.rx_frame_complete = c;
        tick();
        bus_if.rx_word_write     = 1'b0;
        bus_if.rx_frame_complete = 1'b0;
    endtask

    task automatic send_complete_only();
        bus_if.rx_frame_complete = 1'b1;
        tick();
        bus_if.rx_frame_complete = 1'b0;
    endtask

    // Records transferred words until the last one (frame_ready held at 1).
    task automatic collect(input int budget);
        got_n  = 0;
        got_to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.frame_valid && bus_if.frame_ready && got_n < 32) begin
                got_word[got_n] = bus_if.frame_word;
                got_last[got_n] = bus_if.frame_last;
                got_n++;
                if (bus_if.frame_last) begin
                    tick();
                    got_to = 1'b0;
                    break;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        async_reset = 1'b0;
        #2 async_reset = 1'b1;
        tick(); tick();
        n_checks++; if (bus_if.rx_enable !== 1'b0) begin n_fail++; $display("FAIL reset_rx_enable: got %b expected 0", bus_if.rx_enable); end
        n_checks++; if (bus_if.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", bus_if.frame_valid); end
        n_checks++; if (bus_if.frame_last !== 1'b0) begin n_fail++; $display("FAIL reset_frame_last: got %b expected 0", bus_if.frame_last); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        n_checks++; if (bus_if.overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow_err: got %b expected 0", bus_if.overflow_err); end
        n_checks++; if (bus_if.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", bus_if.timeout_err); end
        n_checks++; if (bus_if.frame_len !== 5'd0) begin n_fail++; $display("FAIL reset_frame_len: got %0d expected 0", bus_if.frame_len); end
        async_reset = 1'b0;
        tick();
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_w [3];
        logic       exp_l [3];
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
        exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
        do_arm();
        n_checks++; if (bus_if.rx_enable !== 1'b1) begin n_fail++; $display("FAIL armed_rx_enable: got %b expected 1", bus_if.rx_enable); end
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL armed_busy: got %b expected 1", bus_if.busy); end
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        // One cycle after complete is sampled: in DRAIN, no data yet.
        n_checks++; if (bus_if.frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: frame_valid got %b expected 0", bus_if.frame_valid); end
        n_checks++; if (bus_if.rx_enable !== 1'b0) begin n_fail++; $display("FAIL basic_drain_rx_enable: got %b expected 0", bus_if.rx_enable); end
        n_checks++; if (bus_if.frame_len !== 5'd3) begin n_fail++; $display("FAIL basic_frame_len: got %0d expected 3", bus_if.frame_len); end
        // arm inside DRAIN must be ignored
        bus_if.arm = 1'b1;
        tick();
        bus_if.arm = 1'b0;
        n_checks++; if (bus_if.frame_valid !== 1'b1 || bus_if.frame_word !== 8'h11) begin n_fail++; $display("FAIL basic_latency_first: valid=%b word=%h expected valid=1 word=11", bus_if.frame_valid, bus_if.frame_word); end
        collect(20);
        n_checks++; if (got_to || got_n != 3) begin n_fail++; $display("FAIL basic_count: got %0d words timeout=%b expected 3", got_n, got_to); end
        for (int i = 0; i < 3 && i < got_n; i++) begin
            n_checks++; if (got_word[i] !== exp_w[i] || got_last[i] !== exp_l[i]) begin n_fail++; $display("FAIL basic_word%0d: got %h last=%b expected %h last=%b", i, got_word[i], got_last[i], exp_w[i], exp_l[i]); end
        end
        n_checks++; if (bus_if.frame_valid !== 1'b0 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic_end_idle: valid=%b busy=%b expected 0 0", bus_if.frame_valid, bus_if.busy); end
    endtask

    task automatic test_single_word();
        do_arm();
        send(8'hA5, 1'b1);
        tick();
        n_checks++; if (bus_if.frame_valid !== 1'b1 || bus_if.frame_word !== 8'hA5) begin n_fail++; $display("FAIL single_word: valid=%b word=%h expected 1 a5", bus_if.frame_valid, bus_if.frame_word); end
        n_checks++; if (bus_if.frame_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b expected 1", bus_if.frame_last); end
        n_checks++; if (bus_if.frame_len !== 5'd1) begin n_fail++; $display("FAIL single_len: got %0d expected 1", bus_if.frame_len); end
        tick();
        n_checks++; if (bus_if.frame_valid !== 1'b0 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL single_end: valid=%b busy=%b expected 0 0", bus_if.frame_valid, bus_if.busy); end
    endtask

    task automatic test_overflow();
        int early_pulses;
        int spurious_valid;
        early_pulses   = 0;
        spurious_valid = 0;
        do_arm();
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), 1'b0);
            if (bus_if.overflow_err !== 1'b0) early_pulses++;
        end
        n_checks++; if (early_pulses != 0) begin n_fail++; $display("FAIL ovf_early: got %0d pulses expected 0", early_pulses); end
        send(8'hEE, 1'b0);
        n_checks++; if (bus_if.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", bus_if.overflow_err); end
        send(8'hEF, 1'b0);  // ignored in DISCARD
        n_checks++; if (bus_if.overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_once: got %b expected 0", bus_if.overflow_err); end
        send_complete_only();  // DISCARD -> ARMED
        n_checks++; if (bus_if.rx_enable !== 1'b1 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL ovf_armed: rx_enable=%b busy=%b expected 1 1", bus_if.rx_enable, bus_if.busy); end
        send_complete_only();  // ignored in ARMED
        for (int i = 0; i < 4; i++) begin
            if (bus_if.frame_valid !== 1'b0) spurious_valid++;
            tick();
        end
        n_checks++; if (spurious_valid != 0) begin n_fail++; $display("FAIL ovf_no_output: got %0d valid cycles expected 0", spurious_valid); end
        send(8'h5A, 1'b0);
        send(8'h6B, 1'b1);
        n_checks++; if (bus_if.frame_len !== 5'd2) begin n_fail++; $display("FAIL ovf_next_len: got %0d expected 2", bus_if.frame_len); end
        tick();
        collect(20);
        n_checks++; if (got_to || got_n != 2 || got_word[0] !== 8'h5A || got_word[1] !== 8'h6B) begin n_fail++; $display("FAIL ovf_next_frame: n=%0d w0=%h w1=%h expected 2 5a 6b", got_n, got_word[0], got_word[1]); end
    endtask

    task automatic test_stall();
        logic       stalled;
        logic [7:0] prev_w;
        logic       prev_l;
        int         bad_hold;
        int         bad_rx_en;
        stalled   = 1'b0;
        prev_w    = 8'h00;
        prev_l    = 1'b0;
        bad_hold  = 0;
        bad_rx_en = 0;
        got_n     = 0;
        got_to    = 1'b1;
        do_arm();
        send(8'h81, 1'b0);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b1);
        for (int i = 0; i < 40; i++) begin
            bus_if.frame_ready = i[0];
            if (bus_if.rx_enable !== 1'b0) bad_rx_en++;
            if (stalled && (bus_if.frame_valid !== 1'b1 || bus_if.frame_word !== prev_w || bus_if.frame_last !== prev_l)) bad_hold++;
            if (bus_if.frame_valid && bus_if.frame_ready) begin
                stalled = 1'b0;
                if (got_n < 32) begin
                    got_word[got_n] = bus_if.frame_word;
                    got_last[got_n] = bus_if.frame_last;
                    got_n++;
                end
                if (bus_if.frame_last) begin
                    tick();
                    got_to = 1'b0;
                    break;
                end
            end else if (bus_if.frame_valid) begin
                stalled = 1'b1;
                prev_w  = bus_if.frame_word;
                prev_l  = bus_if.frame_last;
            end else begin
                stalled = 1'b0;
            end
            tick();
        end
        bus_if.frame_ready = 1'b1;
        n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad_hold); end
        n_checks++; if (bad_rx_en != 0) begin n_fail++; $display("FAIL stall_rx_enable: got %0d cycles high expected 0", bad_rx_en); end
        n_checks++; if (got_to || got_n != 4) begin n_fail++; $display("FAIL stall_count: got %0d timeout=%b expected 4", got_n, got_to); end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            n_checks++; if (got_word[i] !== 8'(8'h81 + i) || got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL stall_word%0d: got %h last=%b expected %h last=%b", i, got_word[i], got_last[i], 8'(8'h81 + i), (i == 3)); end
        end
    endtask

    task automatic test_timeout();
        int early;
        int spurious_valid;
        early          = 0;
        spurious_valid = 0;
        do_arm();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
`ifdef RX_FRAME_TIMEOUT_EN
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (bus_if.timeout_err !== 1'b0) early++;
        end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL timeout_early: got %0d pulses expected 0", early); end
        tick();
        n_checks++; if (bus_if.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 1", bus_if.timeout_err); end
        tick();
        n_checks++; if (bus_if.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_once: got %b expected 0", bus_if.timeout_err); end
        send_complete_only();  // ARMED ignores it
        for (int i = 0; i < 4; i++) begin
            if (bus_if.frame_valid !== 1'b0) spurious_valid++;
            tick();
        end
        n_checks++; if (spurious_valid != 0 || bus_if.rx_enable !== 1'b1) begin n_fail++; $display("FAIL timeout_armed: valid cycles=%0d rx_enable=%b expected 0 1", spurious_valid, bus_if.rx_enable); end
        async_reset = 1'b1;
        tick();
        async_reset = 1'b0;
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.timeout_err !== 1'b0) early++;
            if (bus_if.frame_valid !== 1'b0) spurious_valid++;
        end
        n_checks++; if (early != 0 || spurious_valid != 0) begin n_fail++; $display("FAIL no_timeout: pulses=%0d valid=%0d expected 0 0", early, spurious_valid); end
        send_complete_only();  // still CAPTURE, so this closes the frame
        n_checks++; if (bus_if.frame_len !== 5'd2) begin n_fail++; $display("FAIL no_timeout_len: got %0d expected 2", bus_if.frame_len); end
        tick();
        collect(20);
        n_checks++; if (got_to || got_n != 2 || got_word[0] !== 8'h01 || got_word[1] !== 8'h02) begin n_fail++; $display("FAIL no_timeout_frame: n=%0d w0=%h w1=%h expected 2 01 02", got_n, got_word[0], got_word[1]); end
`endif
    endtask

    task automatic test_back_to_back();
        int bad_idle;
        bad_idle          = 0;
        bus_if.continuous = 1'b1;
        do_arm();
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        tick();
        collect(20);
        n_checks++; if (got_to || got_n != 2 || got_word[0] !== 8'h10 || got_word[1] !== 8'h20) begin n_fail++; $display("FAIL b2b_frame1: n=%0d w0=%h w1=%h expected 2 10 20", got_n, got_word[0], got_word[1]); end
        n_checks++; if (bus_if.rx_enable !== 1'b1 || bus_if.frame_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rearm: rx_enable=%b valid=%b expected 1 0", bus_if.rx_enable, bus_if.frame_valid); end
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        send(8'h50, 1'b1);
        n_checks++; if (bus_if.frame_len !== 5'd3) begin n_fail++; $display("FAIL b2b_len2: got %0d expected 3", bus_if.frame_len); end
        tick();
        n_checks++; if (bus_if.frame_valid !== 1'b1 || bus_if.frame_word !== 8'h30) begin n_fail++; $display("FAIL b2b_frame2_first: valid=%b word=%h expected 1 30", bus_if.frame_valid, bus_if.frame_word); end
        tick();
        n_checks++; if (bus_if.frame_word !== 8'h40) begin n_fail++; $display("FAIL b2b_frame2_second: got %h expected 40", bus_if.frame_word); end
        async_reset = 1'b1;
        #1;
        n_checks++; if (bus_if.frame_valid !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.rx_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_async_reset: valid=%b busy=%b rx_enable=%b expected 0 0 0", bus_if.frame_valid, bus_if.busy, bus_if.rx_enable); end
        n_checks++; if (bus_if.frame_len !== 5'd0) begin n_fail++; $display("FAIL b2b_reset_len: got %0d expected 0", bus_if.frame_len); end
        tick();
        async_reset       = 1'b0;
        bus_if.continuous = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.frame_valid !== 1'b0 || bus_if.busy !== 1'b0) bad_idle++;
        end
        n_checks++; if (bad_idle != 0) begin n_fail++; $display("FAIL b2b_after_reset: got %0d active cycles expected 0", bad_idle); end
    endtask

    initial begin
        n_checks                 = 0;
        n_fail                   = 0;
        async_reset              = 1'b0;
        bus_if.arm               = 1'b0;
        bus_if.continuous        = 1'b0;
        bus_if.rx_word           = 8'h00;
        bus_if.rx_word_write     = 1'b0;
        bus_if.rx_frame_complete = 1'b0;
        bus_if.frame_ready       = 1'b1;
        test_reset();
        test_basic_frame();
        test_single_word();
        test_overflow();
        test_stall();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
